// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/interlock logic.
// Forward-select encodings, FSM state encoding and decoder opcodes.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_BUBBLE = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } hz_state_e;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Per-operand forwarding selector: MEM result beats WB result beats regfile.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_regwrite && reg_match(mem_rd, ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && reg_match(wb_rd, ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and interlock unit: forwarding selects, load-use/branch/memory-wait
// sequencing, a saturating stall-cycle counter and a sticky freeze watchdog.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       EX_rs1,
  input  logic [4:0]       EX_rs2,
  input  logic [4:0]       EX_rd,
  input  logic [4:0]       MEM_rd,
  input  logic [4:0]       WB_rd,
  input  logic             EX_RegWrite,
  input  logic             MEM_RegWrite,
  input  logic             WB_RegWrite,
  input  logic             EX_MemRead,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic [1:0]       ForwardA_Sel,
  output logic [1:0]       ForwardB_Sel,
  output logic             Stall,
  output logic             Flush,
  output logic             Freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  hz_state_e        state_q, state_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             stall_timeout_q, stall_timeout_d;

  logic mem_wait, load_use;
  logic stall_c, flush_c, freeze_c;

  forward_sel u_fwd_a (
    .ex_rs       (EX_rs1),
    .mem_rd      (MEM_rd),
    .mem_regwrite(MEM_RegWrite),
    .wb_rd       (WB_rd),
    .wb_regwrite (WB_RegWrite),
    .sel         (ForwardA_Sel)
  );

  forward_sel u_fwd_b (
    .ex_rs       (EX_rs2),
    .mem_rd      (MEM_rd),
    .mem_regwrite(MEM_RegWrite),
    .wb_rd       (WB_rd),
    .wb_regwrite (WB_RegWrite),
    .sel         (ForwardB_Sel)
  );

  // EX_RegWrite is not needed: a load in EX always writes its rd.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = EX_RegWrite;

  assign mem_wait = (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
  assign load_use = EX_MemRead && ((EX_rd != 5'd0) &&
                    ((EX_rd == ID_rs1) || (EX_rd == ID_rs2)));

  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    stall_c      = 1'b0;
    flush_c      = 1'b0;
    freeze_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        freeze_c = mem_wait;
        flush_c  = branch_taken && !mem_wait;
        stall_c  = load_use && !branch_taken && !mem_wait;
        if (mem_wait) begin
          state_d      = ST_MEM_WAIT;
          pend_flush_d = pend_flush_q | branch_taken;
        end else if (stall_c) begin
          state_d = ST_LU_BUBBLE;
        end
      end
      ST_LU_BUBBLE: begin
        freeze_c = mem_wait;
        flush_c  = branch_taken && !mem_wait;
        if (mem_wait) begin
          state_d      = ST_MEM_WAIT;
          pend_flush_d = pend_flush_q | branch_taken;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_wait) begin
          freeze_c     = 1'b1;
          pend_flush_d = pend_flush_q | branch_taken;
        end else begin
          // Release cycle: replay any flush remembered during the wait.
          flush_c      = pend_flush_q | branch_taken;
          stall_c      = load_use && !flush_c;
          pend_flush_d = 1'b0;
          state_d      = stall_c ? ST_LU_BUBBLE : ST_RUN;
        end
      end
      default: begin
        state_d      = ST_RUN;
        pend_flush_d = 1'b0;
      end
    endcase
  end

  // Interlocks are held low for the whole time reset is asserted.
  assign Stall  = stall_c  && rst;
  assign Flush  = flush_c  && rst;
  assign Freeze = freeze_c && rst;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall_c || freeze_c) && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    freeze_cnt_d    = '0;
    stall_timeout_d = stall_timeout_q;
    if (freeze_c) begin
      freeze_cnt_d = (freeze_cnt_q == TO_LAST) ? freeze_cnt_q : freeze_cnt_q + 1'b1;
      if (freeze_cnt_q == TO_LAST) begin
        stall_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_RUN;
      pend_flush_q    <= 1'b0;
      freeze_cnt_q    <= '0;
      stall_cycles_q  <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_flush_q    <= pend_flush_d;
      freeze_cnt_q    <= freeze_cnt_d;
      stall_cycles_q  <= stall_cycles_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (main instance plus a narrow
// counter instance used to reach saturation quickly).
module tb_hazard_unit;
  import hazard_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
  logic       EX_RegWrite, MEM_RegWrite, WB_RegWrite;
  logic       EX_MemRead, MEM_MemRead, MEM_MemWrite, dmem_ready, branch_taken;

  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic        stall, flush, freeze, stall_s, flush_s, freeze_s;
  logic [15:0] stall_cycles;
  logic [2:0]  stall_cycles_s;
  logic        stall_timeout, stall_timeout_s;

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit #(.CNT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .EX_MemRead(EX_MemRead), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .ForwardA_Sel(fwd_a), .ForwardB_Sel(fwd_b),
    .Stall(stall), .Flush(flush), .Freeze(freeze),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  hazard_unit #(.CNT_W(3), .TIMEOUT(4)) dut_small (
    .clk(clk), .rst(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .EX_MemRead(EX_MemRead), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .ForwardA_Sel(fwd_a_s), .ForwardB_Sel(fwd_b_s),
    .Stall(stall_s), .Flush(flush_s), .Freeze(freeze_s),
    .stall_cycles(stall_cycles_s), .stall_timeout(stall_timeout_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    ID_rs1 = 0; ID_rs2 = 0; EX_rs1 = 0; EX_rs2 = 0; EX_rd = 0; MEM_rd = 0; WB_rd = 0;
    EX_RegWrite = 0; MEM_RegWrite = 0; WB_RegWrite = 0;
    EX_MemRead = 0; MEM_MemRead = 0; MEM_MemWrite = 0; dmem_ready = 1; branch_taken = 0;
  endtask

  task automatic set_load_use();
    EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 5'd7; ID_rs2 = 5'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Hazard conditions during reset must not leak to the interlock outputs.
    MEM_MemRead = 1; dmem_ready = 0; branch_taken = 1; set_load_use();
    #3;
    check("rst_freeze", freeze, 0);
    check("rst_flush", flush, 0);
    check("rst_stall", stall, 0);
    check("rst_cycles", stall_cycles, 0);
    check("rst_timeout", stall_timeout, 0);
    @(negedge clk); clear_inputs();
    @(negedge clk); rst_n = 1'b1;

    // Forwarding priority
    @(negedge clk);
    MEM_RegWrite = 1; MEM_rd = 5; WB_RegWrite = 1; WB_rd = 5; EX_rs1 = 5; EX_rs2 = 0; #1;
    check("fwd_a_mem", fwd_a, 2'b10);
    check("fwd_b_x0", fwd_b, 2'b00);
    MEM_rd = 0; #1;
    check("fwd_a_wb", fwd_a, 2'b01);
    MEM_rd = 5; MEM_RegWrite = 0; #1;
    check("fwd_a_mem_nowr", fwd_a, 2'b01);
    EX_rs2 = 5; WB_RegWrite = 0; #1;
    check("fwd_b_none", fwd_b, 2'b00);
    clear_inputs();

    // Load-use: exactly one bubble
    @(negedge clk); set_load_use(); #1;
    check("lu_c1_stall", stall, 1);
    @(negedge clk); #1;
    check("lu_c2_stall", stall, 0);
    @(negedge clk); clear_inputs(); #1;
    check("lu_c3_stall", stall, 0);
    check("lu_cycles", stall_cycles, 1);

    // Branch beats load-use
    @(negedge clk); set_load_use(); branch_taken = 1; #1;
    check("br_lu_flush", flush, 1);
    check("br_lu_stall", stall, 0);
    @(negedge clk); clear_inputs(); #1;
    check("br_lu_cycles", stall_cycles, 1);

    // Memory wait with a branch in the middle: flush replayed on release
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); MEM_MemRead = 1; dmem_ready = 0; branch_taken = (i == 2); #1;
      check($sformatf("mw_c%0d_freeze", i), freeze, 1);
      check($sformatf("mw_c%0d_flush", i), flush, 0);
    end
    @(negedge clk); dmem_ready = 1; branch_taken = 0; #1;
    check("mw_c5_freeze", freeze, 0);
    check("mw_c5_flush", flush, 1);
    @(negedge clk); clear_inputs(); #1;
    check("mw_c6_flush", flush, 0);
    check("mw_cycles", stall_cycles, 5);

    // Watchdog: rises after the 8th consecutive freeze, then sticky
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); MEM_MemRead = 1; dmem_ready = 0; EX_rs2 = 3; MEM_rd = 3; MEM_RegWrite = 1; #1;
      check($sformatf("wd_c%0d_freeze", i), freeze, 1);
      check($sformatf("wd_c%0d_timeout", i), stall_timeout, (i >= 9) ? 1 : 0);
    end
    check("wd_fwd_b_frozen", fwd_b, 2'b10);
    @(negedge clk); dmem_ready = 1; #1;
    check("wd_rel_freeze", freeze, 0);
    check("wd_cycles", stall_cycles, 15);
    check("wd_small_sat", stall_cycles_s, 3'd7);
    check("wd_small_timeout", stall_timeout_s, 1);
    @(negedge clk); clear_inputs();
    @(negedge clk); #1;
    check("wd_sticky", stall_timeout, 1);
    check("wd_small_sat_hold", stall_cycles_s, 3'd7);

    // Asynchronous reset in the middle of a wait with a pending flush
    @(negedge clk); MEM_MemRead = 1; dmem_ready = 0;
    @(negedge clk); branch_taken = 1;
    @(negedge clk); branch_taken = 0; #1;
    check("ar_pre_freeze", freeze, 1);
    rst_n = 1'b0; #1;
    check("ar_freeze", freeze, 0);
    check("ar_flush", flush, 0);
    check("ar_stall", stall, 0);
    check("ar_cycles", stall_cycles, 0);
    check("ar_timeout", stall_timeout, 0);
    check("ar_small_cycles", stall_cycles_s, 0);
    @(negedge clk); clear_inputs();
    @(negedge clk); rst_n = 1'b1; #1;
    check("ar_rel_flush", flush, 0);
    check("ar_rel_freeze", freeze, 0);
    @(negedge clk); #1;
    check("ar_idle_flush", flush, 0);
    @(negedge clk); set_load_use(); #1;
    check("ar_run_stall", stall, 1);
    @(negedge clk); clear_inputs(); #1;
    check("ar_run_cycles", stall_cycles, 1);
    check("ar_run_timeout", stall_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
